// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
// State encoding for the arbiter sequencer and the default operand width.
package div_arb_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// found scanning upward from rr_ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // Scan requesters in pointer order and keep the first one that is asserted.
  always_comb begin
    winner  = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum_s >= NREQ_W) begin
        idx_s = PTR_W'(sum_s - NREQ_W);
      end else begin
        idx_s = sum_s[PTR_W-1:0];
      end
      if (!found_s && req[idx_s]) begin
        winner  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle divider among
// NUM_REQ requesters. One operation per grant; results return on a shared
// bus tagged by a one-hot resp_valid pulse.
// Optional feature macro: DIV_ZERO_BYPASS_EN -- a zero divisor is answered
// directly from IDLE (quotient all ones, remainder = dividend) without
// starting the divider, and an extra div_by_zero pulse accompanies resp_valid.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] divisor_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         quotient_out,
  output logic [WIDTH-1:0]         remainder_out,
  output logic                     busy,
`ifdef DIV_ZERO_BYPASS_EN
  output logic                     div_by_zero,
`endif
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_done
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_e       state_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] owner_r;
  logic             done_armed_r;

  logic [PTR_W-1:0] winner_s;
  logic             any_req_s;
  logic [WIDTH-1:0] win_dividend_s;
  logic [WIDTH-1:0] win_divisor_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Select the winner's operand slices for latching at grant time.
  always_comb begin
    win_dividend_s = '0;
    win_divisor_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_s == PTR_W'(i)) begin
        win_dividend_s = dividend_in[i*WIDTH +: WIDTH];
        win_divisor_s  = divisor_in[i*WIDTH +: WIDTH];
      end else begin
        win_dividend_s = win_dividend_s;
      end
    end
  end

  // Sequencer: grant, start divider, wait for a fresh done, return result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      rr_ptr_r      <= '0;
      owner_r       <= '0;
      done_armed_r  <= 1'b0;
      gnt           <= '0;
      resp_valid    <= '0;
      busy          <= 1'b0;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
`ifdef DIV_ZERO_BYPASS_EN
      div_by_zero   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid <= '0;
          div_start  <= 1'b0;
          if (any_req_s) begin
            gnt          <= ONE << winner_s;
            owner_r      <= winner_s;
            div_dividend <= win_dividend_s;
            div_divisor  <= win_divisor_s;
            busy         <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            // Zero divisor: answer immediately, the divider is never started.
            if (win_divisor_s == {WIDTH{1'b0}}) begin
              quotient_out  <= {WIDTH{1'b1}};
              remainder_out <= win_dividend_s;
              resp_valid    <= ONE << winner_s;
              div_by_zero   <= 1'b1;
              state_r       <= RESP;
            end else begin
              state_r       <= ISSUE;
            end
`else
            state_r      <= ISSUE;
`endif
          end else begin
            gnt     <= '0;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          gnt          <= '0;
          div_start    <= 1'b1;
          done_armed_r <= 1'b0;
          busy         <= 1'b1;
          state_r      <= WAIT;
        end
        WAIT: begin
          div_start <= 1'b0;
          // div_done is sticky from the previous operation; only a high level
          // seen after a low sample belongs to the current operation.
          if (div_done && done_armed_r) begin
            quotient_out  <= div_quotient;
            remainder_out <= div_remainder;
            resp_valid    <= ONE << owner_r;
            state_r       <= RESP;
          end else if (!div_done) begin
            done_armed_r  <= 1'b1;
          end else begin
            state_r       <= WAIT;
          end
        end
        RESP: begin
          gnt        <= '0;
          resp_valid <= '0;
          busy       <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
          div_by_zero <= 1'b0;
`endif
          if (owner_r == LAST_IDX) begin
            rr_ptr_r <= '0;
          end else begin
            rr_ptr_r <= owner_r + PTR_W'(1);
          end
          state_r <= IDLE;
        end
        default: begin
          gnt        <= '0;
          resp_valid <= '0;
          div_start  <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle 16-bit divider unit among NUM_REQ requesters (e.g. execute lanes, address-gen unit).
- Grants one requester at a time, latches its operands and issues a start pulse to the divider.
- Waits for completion, then returns quotient/remainder on a shared result bus with a one-hot valid.
- Sits between the processor's requesters and the divider instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width; must match the divider
PTR_W, $clog2(NUM_REQ), localparam, width of the round-robin pointer and owner index

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  level request per requester
dividend_in  input  NUM_REQ*WIDTH  packed dividends; requester i in bits [i*WIDTH +: WIDTH]
divisor_in  input  NUM_REQ*WIDTH  packed divisors, same packing
gnt  output  NUM_REQ  one-hot, one-cycle grant pulse
resp_valid  output  NUM_REQ  one-hot, one-cycle result-valid pulse
quotient_out  output  WIDTH  result quotient, valid when resp_valid != 0
remainder_out  output  WIDTH  result remainder, valid when resp_valid != 0
busy  output  1  high in every state except IDLE
div_start  output  1  start pulse to the divider
div_dividend  output  WIDTH  operand to the divider
div_divisor  output  WIDTH  operand to the divider
div_quotient  input  WIDTH  from the divider
div_remainder  input  WIDTH  from the divider
div_done  input  1  from the divider; sticky high until the next start is accepted

Behaviour:
- All outputs are registered. On reset: state=IDLE; rr_ptr=0; gnt, resp_valid, div_start, busy=0; div_dividend, div_divisor, quotient_out, remainder_out=0; done_armed=0.
- Reset asserted mid-operation aborts it with no response. The divider shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding).
- IDLE, req != 0:
  - Winner = first asserted req scanning from rr_ptr upward, wrapping at NUM_REQ.
  - Next edge: gnt[winner]=1, owner=winner, div_dividend/div_divisor latched from the winner's slice, go to ISSUE.
  - With req == 0, stay in IDLE.
- ISSUE: gnt=0, div_start=1 for exactly one cycle, done_armed=0, go to WAIT.
- WAIT: div_start=0.
  - div_done is sticky from the previous operation, so a high level is ignored until it has been sampled low once (done_armed set when div_done==0).
  - On div_done==1 with done_armed==1: latch div_quotient/div_remainder into the outputs, resp_valid[owner]=1, go to RESP.
- RESP: resp_valid=0, rr_ptr=(owner+1) wrapping to 0 at NUM_REQ, go to IDLE.
- div_dividend and div_divisor hold stable from ISSUE until the next grant, because the divider samples them after start.
- Request protocol:
  - One operation per grant.
  - A requester wanting a single operation drops req by the edge after it sees gnt.
  - A req still high when the arbiter returns to IDLE is treated as a new request.
  - Operands need only be valid in the cycle the winner is selected.
- Latency: grant 1 cycle after req is seen in IDLE; resp_valid 1 cycle after armed div_done; minimum 2 idle-state cycles between back-to-back grants (RESP, IDLE).
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Simultaneous requests resolve by the pointer only, with no fixed priority.
- No overlap: requests arriving during ISSUE/WAIT/RESP are held by the requester and are not queued in the arbiter.

Optional Feature:
DIV_ZERO_BYPASS_EN
- Defined: in IDLE, a winner with divisor==0 is granted, but the divider is not started. State goes IDLE->RESP directly, with quotient_out={WIDTH{1'b1}}, remainder_out=dividend and resp_valid[owner]=1 in the same edge as gnt.
  - Adds output div_by_zero (1 bit), pulsed alongside resp_valid.
- Undefined: divisor 0 is sent to the divider like any other operand; no div_by_zero port.

Decomposition:
- Package div_arb_pkg: state enum constants (IDLE/ISSUE/WAIT/RESP) and a default WIDTH constant.
- One natural sub-module: rr_pick (combinational round-robin priority selector: req, rr_ptr -> winner index, any_req), reusable by other arbiters.

Test Plan:
- Single op: req=0001, dividend0=100, divisor0=7 -> gnt=0001 next cycle, one div_start pulse, resp_valid=0001 with quotient_out=14, remainder_out=2.
- All four requesting continuously, distinct operands -> grant order 0,1,2,3,0, each resp_valid routed to the granted index with its own correct result.
- Stale done: second op issued while div_done is still high from the first -> no response until div_done falls and rises again; result matches the second operands.
- Operands change right after gnt (dividend0 100->5) -> result still 100/7; div_dividend stays stable through WAIT.
- Reset asserted in WAIT -> all outputs 0 immediately; next req=0010 is granted with rr_ptr=0 scan, and the op completes correctly.
- DIV_ZERO_BYPASS_EN defined, divisor=0, dividend=0x1234 -> no div_start; quotient_out=0xFFFF, remainder_out=0x1234, div_by_zero pulse.
